// File: rtl/watchdog_reset_req.sv
// watchdog_reset_req
//   Watchdog that asks for a system reset when software stops kicking it.
//   A millisecond-style prescaler (ms_cnt) feeds a timeout counter (to_cnt).
//   If TIMEOUT_MS ticks pass without a kick while armed, a PULSE_CYCLES wide
//   reset request is issued, followed by a HOLDOFF_CYCLES quiet period.
//
// Ports
//   clk           system clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   enable        arms the watchdog while high
//   kick          single-cycle keep-alive strobe
//   clr_flag      clears timeout_flag (a simultaneous fire keeps it set)
//   wdt_rst_o     registered reset request, active-high
//   wdt_rst_n_o   inverse of wdt_rst_o
//   timeout_flag  sticky "a fire has occurred" flag
//   fire_cnt      saturating count of fires, cleared only by rst
module watchdog_reset_req #(
  parameter int unsigned SYS_CYCLE      = 'd20,
  parameter int unsigned MS_WAIT_TIME   = 'd1000000,
  parameter int unsigned TIMEOUT_MS     = 'd100,
  parameter int unsigned PULSE_CYCLES   = 'd16,
  parameter int unsigned HOLDOFF_CYCLES = 'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       kick,
  input  logic       clr_flag,
  output logic       wdt_rst_o,
  output logic       wdt_rst_n_o,
  output logic       timeout_flag,
  output logic [7:0] fire_cnt
);

  localparam logic [16:0] MS_CNT_MAX = 17'(MS_WAIT_TIME / SYS_CYCLE - 1);
  localparam logic [10:0] TO_LAST    = 11'(TIMEOUT_MS - 1);
  localparam logic [7:0]  PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0]  HOLD_LAST  = 8'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [16:0] ms_cnt;
  logic [10:0] to_cnt;
  logic [7:0]  pulse_cnt;
  logic        arm_first;
  logic        ms_tick;
  logic        timeout_hit;
  logic        fire_start;

  assign ms_tick     = (ms_cnt == MS_CNT_MAX);
  assign timeout_hit = ms_tick && (to_cnt == TO_LAST) && !kick && enable;
  assign wdt_rst_n_o = ~wdt_rst_o;

  // Next-state decode. In ARMED, dropping enable beats a kick, and a kick
  // beats the timeout even on the final tick.
  always_comb begin
    next_state = state;
    fire_start = 1'b0;
    case (state)
      IDLE: begin
        if (enable) next_state = ARMED;
      end
      ARMED: begin
        if (!enable) begin
          next_state = IDLE;
        end else if (kick) begin
          next_state = ARMED;
        end else if (timeout_hit) begin
          next_state = FIRE;
          fire_start = 1'b1;
        end
      end
      FIRE: begin
        if (pulse_cnt == PULSE_LAST) next_state = HOLD;
      end
      HOLD: begin
        if (pulse_cnt == HOLD_LAST) next_state = enable ? ARMED : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Marks the first cycle spent in ARMED so the prescaler restarts there,
  // which makes an arm behave exactly like a kick on the entry cycle.
  always_ff @(posedge clk) begin
    if (rst) arm_first <= 1'b0;
    else     arm_first <= (state != ARMED) && (next_state == ARMED);
  end

  // Prescaler and timeout counter only run in ARMED; everywhere else, on the
  // entry cycle and on a kick they restart from zero.
  always_ff @(posedge clk) begin
    if (rst || (state != ARMED) || arm_first || kick) begin
      ms_cnt <= '0;
      to_cnt <= '0;
    end else begin
      ms_cnt <= ms_tick ? 17'd0 : ms_cnt + 17'd1;
      if (ms_tick) to_cnt <= to_cnt + 11'd1;
    end
  end

  // pulse_cnt times both the FIRE pulse and the HOLD quiet period; it
  // restarts whenever either phase ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_cnt <= '0;
    end else if ((state == FIRE || state == HOLD) && (next_state == state)) begin
      pulse_cnt <= pulse_cnt + 8'd1;
    end else begin
      pulse_cnt <= '0;
    end
  end

  // Reset request is registered from the next state, so it is high exactly
  // while the FSM sits in FIRE.
  always_ff @(posedge clk) begin
    if (rst) wdt_rst_o <= 1'b0;
    else     wdt_rst_o <= (next_state == FIRE);
  end

  // Sticky flag and saturating fire counter, updated on the FIRE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_flag <= 1'b0;
      fire_cnt     <= '0;
    end else begin
      if (fire_start)    timeout_flag <= 1'b1;
      else if (clr_flag) timeout_flag <= 1'b0;
      if (fire_start && (fire_cnt != 8'hFF)) fire_cnt <= fire_cnt + 8'd1;
    end
  end

endmodule
